// File: rtl/seg_disp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_scheduler_if
// Description : Write-request bundle for the two requesters (A, B) of the
//               seven-segment digit store.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_disp_scheduler_if;
    logic       req_a;
    logic [3:0] num_a;
    logic [2:0] sel_a;
    logic       gnt_a;
    logic       req_b;
    logic [3:0] num_b;
    logic [2:0] sel_b;
    logic       gnt_b;

    modport master (
        output req_a, num_a, sel_a, req_b, num_b, sel_b,
        input  gnt_a, gnt_b
    );

    modport slave (
        input  req_a, num_a, sel_a, req_b, num_b, sel_b,
        output gnt_a, gnt_b
    );
endinterface
`default_nettype wire

// File: rtl/seg_disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_scheduler
// Description : 8x4-bit digit store with round-robin two-port write arbitration
//               and time-multiplexed active-low seven-segment scan.
//               Optional macro LEADING_ZERO_BLANK_EN auto-blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_disp_scheduler #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_disp_scheduler_if.slave   wr,
    input  logic [NUM_DIGITS-1:0] blank,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic [2:0]            scan_idx
);

    localparam int                c_div_w    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(REFRESH_DIV - 1);

    logic [7:0][3:0]          store_q, store_d;
    logic                     favour_b_q, favour_b_d;
    logic                     gnt_a_q, gnt_a_d;
    logic                     gnt_b_q, gnt_b_d;
    logic [c_div_w-1:0]       div_q, div_d;
    logic [2:0]               scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]    anode_q, anode_d;
    logic [6:0]               seg_q, seg_d;

    logic                     win_a;
    logic                     win_b;
    logic                     div_last;
    logic                     dark;
    logic [7:0]               auto_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Pointer side wins a tie and the pointer then moves to the loser.
    always_comb begin
        win_a      = wr.req_a && (!wr.req_b || !favour_b_q);
        win_b      = wr.req_b && !win_a;
        favour_b_d = favour_b_q;
        if (wr.req_a && wr.req_b) begin
            favour_b_d = win_a;
        end
        store_d = store_q;
        if (win_a) begin
            store_d[wr.sel_a] = wr.num_a;
        end else if (win_b) begin
            store_d[wr.sel_b] = wr.num_b;
        end
        gnt_a_d = win_a;
        gnt_b_d = win_b;
    end

    always_comb begin
        auto_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic zero_run;
            zero_run = 1'b1;
            for (int i = 7; i >= 1; i--) begin
                zero_run      = zero_run && (store_q[i] == 4'd0);
                auto_blank[i] = zero_run;
            end
        end
`endif
    end

    // Display registers are all computed from the next scan index so that
    // anode, seg and scan_idx always describe the same digit.
    always_comb begin
        div_last   = (div_q == c_div_last);
        div_d      = div_last ? '0 : div_q + c_div_w'(1);
        scan_idx_d = div_last ? scan_idx_q + 3'd1 : scan_idx_q;
        dark       = blank[scan_idx_d] | auto_blank[scan_idx_d];
        anode_d    = dark ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << scan_idx_d);
        seg_d      = dark ? 7'h7F : hex_to_seg(store_q[scan_idx_d]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_q    <= '0;
            favour_b_q <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            div_q      <= '0;
            scan_idx_q <= 3'd0;
            anode_q    <= {NUM_DIGITS{1'b1}};
            seg_q      <= 7'h7F;
        end else begin
            store_q    <= store_d;
            favour_b_q <= favour_b_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            div_q      <= div_d;
            scan_idx_q <= scan_idx_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
        end
    end

    assign wr.gnt_a = gnt_a_q;
    assign wr.gnt_b = gnt_b_q;
    assign anode    = anode_q;
    assign seg      = seg_q;
    assign scan_idx = scan_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_disp_scheduler
// Description : Randomised self-checking bench for seg_disp_scheduler against
//               a cycle-count based reference model of store, arbiter and scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_disp_scheduler;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] blank = 8'h00;
    logic [7:0] anode;
    logic [6:0] seg;
    logic [2:0] scan_idx;

    seg_disp_scheduler_if wr_if();

    seg_disp_scheduler #(.NUM_DIGITS(8), .REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr_if),
        .blank    (blank),
        .anode    (anode),
        .seg      (seg),
        .scan_idx (scan_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: store contents, who wins the next tie, edges since reset.
    logic [3:0] m_store [8];
    bit         m_next_b;
    int         m_edges;
    logic [7:0] e_anode;
    logic [6:0] e_seg;
    logic [2:0] e_idx;
    logic       e_ga, e_gb;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'h0: lit = 7'b1111110;  4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;  4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;  4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;  4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;  4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;  4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;  4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;  default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

    function automatic bit digit_dark(input int idx);
        bit d;
        d = blank[idx];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0) begin
            bit allz;
            allz = 1'b1;
            for (int j = idx; j < 8; j++) if (m_store[j] != 4'd0) allz = 1'b0;
            if (allz) d = 1'b1;
        end
`endif
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_store[i] = 4'd0;
        m_next_b = 1'b0;
        m_edges  = 0;
        e_anode  = 8'hFF;
        e_seg    = 7'h7F;
        e_idx    = 3'd0;
        e_ga     = 1'b0;
        e_gb     = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_if.req_a = 1'b0; wr_if.num_a = 4'd0; wr_if.sel_a = 3'd0;
        wr_if.req_b = 1'b0; wr_if.num_b = 4'd0; wr_if.sel_b = 3'd0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        m_edges++;
        e_idx = 3'((m_edges / DIV) % 8);
        if (digit_dark(int'(e_idx))) begin
            e_anode = 8'hFF;
            e_seg   = 7'h7F;
        end else begin
            e_anode = ~(8'b1 << e_idx);
            e_seg   = seg_code(m_store[e_idx]);
        end
        e_ga = 1'b0;
        e_gb = 1'b0;
        if (wr_if.req_a && wr_if.req_b) begin
            if (m_next_b) e_gb = 1'b1; else e_ga = 1'b1;
            m_next_b = !m_next_b;
        end else if (wr_if.req_a) begin
            e_ga = 1'b1;
        end else if (wr_if.req_b) begin
            e_gb = 1'b1;
        end
        if (e_ga) m_store[wr_if.sel_a] = wr_if.num_a;
        if (e_gb) m_store[wr_if.sel_b] = wr_if.num_b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        wr_if.req_a = 1'b1; wr_if.num_a = 4'h5; wr_if.sel_a = 3'd0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({anode, seg, wr_if.gnt_a, wr_if.gnt_b} !== {8'hFF, 7'h7F, 2'b00}) begin
                errors++;
                $display("FAIL reset_hold: got anode=%h seg=%b ga=%b gb=%b exp anode=ff seg=1111111 ga=0 gb=0",
                         anode, seg, wr_if.gnt_a, wr_if.gnt_b);
            end
        end
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if ({anode, seg, scan_idx} !== {8'hFE, 7'b0000001, 3'd0}) begin
            errors++;
            $display("FAIL reset_release: got anode=%h seg=%b idx=%0d exp anode=fe seg=0000001 idx=0",
                     anode, seg, scan_idx);
        end
    endtask

    task automatic test_single_writes();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                wr_if.req_a = (ph == 0); wr_if.num_a = 4'(i); wr_if.sel_a = 3'(i);
                step();
                if (wr_if.gnt_a === 1'b1) pulses++;
                checks++;
                if ({anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b} !== {e_anode, e_seg, e_idx, e_ga, e_gb}) begin
                    errors++;
                    $display("FAIL single_write: got an=%h seg=%b idx=%0d ga=%b gb=%b exp an=%h seg=%b idx=%0d ga=%b gb=%b",
                             anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b, e_anode, e_seg, e_idx, e_ga, e_gb);
                end
            end
        end
        idle_inputs();
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL single_gnt_count: got %0d grants exp 8", pulses);
        end
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            step();
            checks++;
            if ({anode, seg, scan_idx} !== {e_anode, e_seg, e_idx}) begin
                errors++;
                $display("FAIL single_scan: got an=%h seg=%b idx=%0d exp an=%h seg=%b idx=%0d",
                         anode, seg, scan_idx, e_anode, e_seg, e_idx);
            end
        end
    endtask

    task automatic test_contention();
        bit found;
        wr_if.req_a = 1'b1; wr_if.num_a = 4'd3; wr_if.sel_a = 3'd2;
        wr_if.req_b = 1'b1; wr_if.num_b = 4'd9; wr_if.sel_b = 3'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({wr_if.gnt_a, wr_if.gnt_b} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_order: grant %0d got ga=%b gb=%b exp %s", k,
                         wr_if.gnt_a, wr_if.gnt_b, (k % 2 == 0) ? "A" : "B");
            end
        end
        idle_inputs();
        found = 1'b0;
        for (int c = 0; c < 10 * DIV && !found; c++) begin
            step();
            if (e_idx == 3'd2) found = 1'b1;
        end
        checks++;
        if (!found || seg !== 7'b0000100) begin
            errors++;
            $display("FAIL contention_store: found=%0d got seg=%b exp seg=0000100 (digit 9)", found, seg);
        end
    endtask

    task automatic test_blanking();
        for (int i = 0; i < 8; i++) begin
            wr_if.req_b = 1'b1; wr_if.num_b = 4'(8 + i); wr_if.sel_b = 3'(i);
            step();
            idle_inputs();
            step();
        end
        blank = 8'h0F;
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            step();
            checks++;
            if ({anode, seg, scan_idx} !== {e_anode, e_seg, e_idx}) begin
                errors++;
                $display("FAIL blank_scan: got an=%h seg=%b idx=%0d exp an=%h seg=%b idx=%0d",
                         anode, seg, scan_idx, e_anode, e_seg, e_idx);
            end
            if (e_idx == 3'd4) begin
                checks++;
                if ({anode, seg} !== {8'hEF, 7'b0110001}) begin
                    errors++;
                    $display("FAIL blank_digit4: got an=%h seg=%b exp an=ef seg=0110001", anode, seg);
                end
            end
        end
        blank = 8'h00;
    endtask

    task automatic test_live_update();
        logic [2:0] target;
        int guard;
        guard = 0;
        step();
        while ((m_edges % DIV) != 0 && guard < 2 * DIV) begin
            step();
            guard++;
        end
        target = e_idx;
        wr_if.req_a = 1'b1; wr_if.num_a = 4'hF; wr_if.sel_a = target;
        step();
        idle_inputs();
        checks++;
        if ({anode, seg, wr_if.gnt_a} !== {e_anode, e_seg, 1'b1}) begin
            errors++;
            $display("FAIL live_first: got an=%h seg=%b ga=%b exp an=%h seg=%b ga=1",
                     anode, seg, wr_if.gnt_a, e_anode, e_seg);
        end
        step();
        checks++;
        if (seg !== 7'b0111000 || scan_idx !== target) begin
            errors++;
            $display("FAIL live_update: got seg=%b idx=%0d exp seg=0111000 idx=%0d", seg, scan_idx, target);
        end
    endtask

    task automatic test_leading_zero();
        bit exp_dark;
        do_reset();
        wr_if.req_a = 1'b1; wr_if.num_a = 4'h4; wr_if.sel_a = 3'd1;
        wr_if.req_b = 1'b1; wr_if.num_b = 4'h2; wr_if.sel_b = 3'd0;
        step();
        step();
        idle_inputs();
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            step();
`ifdef LEADING_ZERO_BLANK_EN
            exp_dark = (e_idx >= 3'd2);
`else
            exp_dark = 1'b0;
`endif
            checks++;
            if ({anode, seg, scan_idx} !== {e_anode, e_seg, e_idx} || (anode === 8'hFF) !== exp_dark) begin
                errors++;
                $display("FAIL leading_zero: got an=%h seg=%b idx=%0d exp an=%h seg=%b idx=%0d dark=%0d",
                         anode, seg, scan_idx, e_anode, e_seg, e_idx, exp_dark);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wr_if.req_a = 1'($urandom_range(0, 1)); wr_if.num_a = 4'($urandom); wr_if.sel_a = 3'($urandom);
            wr_if.req_b = 1'($urandom_range(0, 1)); wr_if.num_b = 4'($urandom); wr_if.sel_b = 3'($urandom);
            if (c % 16 == 0) blank = 8'($urandom) & 8'($urandom);
            step();
            checks++;
            if ({anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b} !== {e_anode, e_seg, e_idx, e_ga, e_gb}) begin
                errors++;
                $display("FAIL random: cycle %0d got an=%h seg=%b idx=%0d ga=%b gb=%b exp an=%h seg=%b idx=%0d ga=%b gb=%b",
                         c, anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b, e_anode, e_seg, e_idx, e_ga, e_gb);
            end
        end
        idle_inputs();
        blank = 8'h00;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 10 * DIV && !found; c++) begin
            step();
            if (e_idx == 3'd5) found = 1'b1;
        end
        wr_if.req_a = 1'b1; wr_if.num_a = 4'h7; wr_if.sel_a = 3'd5;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (!found || {anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b} !== {8'hFF, 7'h7F, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL async_reset: found=%0d got an=%h seg=%b idx=%0d ga=%b gb=%b exp an=ff seg=1111111 idx=0 g=00",
                     found, anode, seg, scan_idx, wr_if.gnt_a, wr_if.gnt_b);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({wr_if.gnt_a, wr_if.gnt_b} !== 2'b00) begin
                errors++;
                $display("FAIL async_reset_gnt: got ga=%b gb=%b exp 00", wr_if.gnt_a, wr_if.gnt_b);
            end
        end
        idle_inputs();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            step();
            checks++;
            if ({anode, seg, scan_idx} !== {e_anode, e_seg, e_idx}) begin
                errors++;
                $display("FAIL post_reset_scan: got an=%h seg=%b idx=%0d exp an=%h seg=%b idx=%0d",
                         anode, seg, scan_idx, e_anode, e_seg, e_idx);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_writes();
        test_contention();
        test_blanking();
        test_live_update();
        test_random();
        test_async_reset();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_disp_scheduler.md
Name: seg_disp_scheduler

Overview:
- Owns the 8-entry x 4-bit digit store for the board's 8-digit seven-segment display.
- Round-robin arbitrates two write requesters (A, B) onto the single store write port.
- Time-multiplexes the stored digits onto active-low anodes and segments.
- Sits between the user/control logic (switch inputs, counters) and the display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; fixed 8 in this design (anode and blank widths follow it).
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range 2..2^20.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- req_a  in  1  requester A write request, level
- num_a  in  4  requester A digit value
- sel_a  in  3  requester A digit index
- gnt_a  out  1  one-cycle pulse: A's write committed
- req_b  in  1  requester B write request, level
- num_b  in  4  requester B digit value
- sel_b  in  3  requester B digit index
- gnt_b  out  1  one-cycle pulse: B's write committed
- blank  in  8  per-digit blank; 1 = digit dark
- anode  out  8  active-low digit enables; bit i = digit i
- seg  out  7  active-low segments; seg[6]=a ... seg[0]=g
- scan_idx  out  3  digit index currently driven

Behaviour:
- Reset (rst=0, async) sets:
  - all store entries to 0; gnt_a=gnt_b=0; anode=8'hFF; seg=7'h7F; scan_idx=0.
  - divider=0; round-robin pointer favouring A.
- Arbitration is sampled each rising edge.
  - Only one request high: that requester wins.
  - Both high: the pointer side wins, then the pointer moves to the loser. The pointer is unchanged when there is 0 or 1 request.
- Winner's num is written to store[sel] at that edge. Its gnt is 1 for exactly the following cycle, 0 otherwise.
- gnt_a and gnt_b are never high together.
- req is level-sensitive. A requester still high in its gnt cycle is a new request and may be granted again.
  - Both requesters held high: grants alternate A, B, A, B...
- Both requesters targeting the same sel: only the winner writes. The loser is written on a later grant and overwrites the winner's value.
- Divider counts 0..REFRESH_DIV-1. On terminal count it returns to 0 and scan_idx increments, wrapping 7 -> 0.
- anode, seg and scan_idx are registered and use the same scan_idx value.
  - anode = ~(1<<scan_idx), or 8'hFF if blank[scan_idx]=1.
  - seg = hex decode of store[scan_idx], or 7'h7F if blanked.
  - Example codes: 0 -> 0000001, 1 -> 1001111, 8 -> 0000000, F -> 0111000.
- A write to the digit being displayed updates seg on the cycle after the store write (2 cycles after req sampled).
- The scan never stalls for writes.
- Reset mid-write: the write is lost, no gnt is issued, and the store is cleared.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (1..7) is additionally blanked when it and every higher digit hold 0.
  - Digit 0 is never auto-blanked.
  - Blanking is evaluated from the current store contents on the same registered path.
- Undefined: only the blank input blanks digits.

Test Plan:
- Reset → while rst=0: anode=8'hFF, seg=7'h7F, gnt_a=gnt_b=0. Release with REFRESH_DIV=4 → first anode=8'hFE, seg=0000001.
- Single writes (REFRESH_DIV=4): A writes 0..7 to sel 0..7, one req pulse each → one gnt_a pulse per write. Full scan shows digit i lit (anode bit i low) with seg = decode(i); each digit lasts 4 cycles; wrap 7 -> 0.
- Contention: req_a=req_b=1 for 4 cycles, num_a=3/sel_a=2, num_b=9/sel_b=2 → gnts A, B, A, B; store[2]=9 after the last B grant.
- Blanking: blank=8'h0F after loading 8..F → digits 0-3 anode 8'hFF; digit 4 shows 4'hC.
- Live update: write F to the currently scanned digit → seg becomes 0111000 two cycles after req.
- Async reset mid-scan at scan_idx=5 → outputs reset immediately, no clock needed; store reads 0 afterwards. With LEADING_ZERO_BLANK_EN: store=0000_0042 (hex) shows only digits 1 and 0.
